imem_dmem_arbiter: RTL and testbench

- Shares the single unified memory port between instruction fetch (IF) and load/store unit (LSU) in the NPC core.
- Allows one outstanding transaction at a time.
- Uses valid/ready request handshakes and pulses a response back to the requester that owns the transaction.
- Sits between the IF/LSU stages and the memory model; address masking matches the memory's 0x7fffffff window.

---
 rtl/imem_dmem_arb_pkg.sv | 22 ++
 rtl/arb_pick.sv | 40 ++++
 rtl/imem_dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_dmem_arb_pkg.sv
// imem_dmem_arb_pkg
//   Shared types and constants for the IF/LSU memory-port arbiter.
//   state_e           : transaction phase of the arbiter
//   owner_e           : which requester owns the current transaction
//   ADDR_MASK_DEFAULT : address window of the memory model
package imem_dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [63:0] ADDR_MASK_DEFAULT = 64'h0000_0000_7fff_ffff;

endpackage

// File: rtl/arb_pick.sv
// arb_pick
//   Combinational winner select between the IF and LSU requesters.
//   Build option: ARB_RR_EN
//     defined   -> on a simultaneous request the side not granted last wins
//     undefined -> fixed priority, LSU always wins; last_grant_i is ignored
//   Ports:
//     if_valid_i   : IF request pending
//     lsu_valid_i  : LSU request pending
//     last_grant_i : owner of the previously accepted request
//     grant_o      : winner (OWN_IF when nobody requests)
module arb_pick
  import imem_dmem_arb_pkg::*;
(
  input  logic   if_valid_i,
  input  logic   lsu_valid_i,
  input  owner_e last_grant_i,
  output owner_e grant_o
);

`ifdef ARB_RR_EN
  always_comb begin
    grant_o = OWN_IF;
    if (if_valid_i && lsu_valid_i) begin
      grant_o = (last_grant_i == OWN_LSU) ? OWN_IF : OWN_LSU;
    end else if (lsu_valid_i) begin
      grant_o = OWN_LSU;
    end
  end
`else
  // Fixed priority only needs the LSU valid; the other inputs are kept so
  // both builds share one port list.
  logic unused_inputs;
  assign unused_inputs = if_valid_i ^ last_grant_i;

  always_comb begin
    grant_o = lsu_valid_i ? OWN_LSU : OWN_IF;
  end
`endif

endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares the unified memory port between instruction fetch (IF) and the
//   load/store unit (LSU). One transaction is outstanding at a time:
//   IDLE (accept) -> REQ (present to memory) -> WAIT (await data) -> RESP
//   (one-cycle response pulse to the owner) -> IDLE.
//   Build option: ARB_RR_EN selects round-robin instead of fixed LSU priority.
//   Ports:
//     clock, reset_n                 : clock (rising edge), async active-low reset
//     if_req_*  / if_resp_*          : IF fetch request / 32-bit instruction response
//     lsu_req_* / lsu_resp_*         : LSU load/store request / load data or store ack
//     mem_req_*, mem_addr/wen/wdata/wmask : request towards memory (address masked)
//     mem_resp_valid, mem_resp_rdata : memory response strobe and data
module imem_dmem_arbiter
  import imem_dmem_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       DATA_W    = 64,
  parameter logic [ADDR_W-1:0] ADDR_MASK = ADDR_MASK_DEFAULT[ADDR_W-1:0]
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [31:0]         if_resp_inst,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  state_e                state_q, state_d;
  owner_e                owner_q;
  owner_e                grant;
  owner_e                last_grant;
  logic                  accept;
  logic                  capture;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wen_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic [31:0]           inst_q;
  logic [DATA_W-1:0]     lsu_rdata_q;

  arb_pick u_pick (
    .if_valid_i   (if_req_valid),
    .lsu_valid_i  (lsu_req_valid),
    .last_grant_i (last_grant),
    .grant_o      (grant)
  );

`ifdef ARB_RR_EN
  // Resets to LSU so that IF wins the first simultaneous request.
  owner_e last_grant_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= OWN_LSU;
    end else if (accept) begin
      last_grant_q <= grant;
    end
  end
  assign last_grant = last_grant_q;
`else
  assign last_grant = OWN_LSU;
`endif

  assign accept = (state_q == IDLE) && (if_req_valid || lsu_req_valid);

  // Data is taken either together with the request acceptance in REQ or later
  // in WAIT; any other response strobe is not ours and is dropped.
  assign capture = ((state_q == REQ) && mem_req_ready && mem_resp_valid) ||
                   ((state_q == WAIT) && mem_resp_valid);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (mem_req_ready) state_d = mem_resp_valid ? RESP : WAIT;
      WAIT:    if (mem_resp_valid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset_n so nothing is granted while reset is held.
  always_comb begin
    if_req_ready   = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    if_resp_valid  = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if_req_ready  = reset_n && if_req_valid && (grant == OWN_IF);
        lsu_req_ready = reset_n && lsu_req_valid && (grant == OWN_LSU);
      end
      REQ:  mem_req_valid = 1'b1;
      RESP: begin
        if (owner_q == OWN_LSU) lsu_resp_valid = 1'b1;
        else                    if_resp_valid  = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields stay frozen from acceptance until the next acceptance;
  // response data registers are per requester so each holds until that
  // requester's next response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      inst_q      <= '0;
      lsu_rdata_q <= '0;
    end else begin
      if (accept) begin
        owner_q <= grant;
        if (grant == OWN_LSU) begin
          addr_q  <= lsu_req_addr & ADDR_MASK;
          wen_q   <= lsu_req_wen;
          wdata_q <= lsu_req_wdata;
          wmask_q <= lsu_req_wmask;
        end else begin
          addr_q  <= if_req_addr & ADDR_MASK;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end
      if (capture) begin
        if (owner_q == OWN_IF) begin
          inst_q <= addr_q[2] ? mem_resp_rdata[63:32] : mem_resp_rdata[31:0];
        end else begin
          lsu_rdata_q <= wen_q ? '0 : mem_resp_rdata;
        end
      end
    end
  end

  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign if_resp_inst   = inst_q;
  assign lsu_resp_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter
//   Directed scenarios with literal expectations, then randomized traffic
//   checked every cycle against a transaction-level reference model.
//   Honours ARB_RR_EN for the expected arbitration order.
module tb_imem_dmem_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif
  localparam logic [63:0] MASK = 64'h0000_0000_7fff_ffff;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_req_addr;
  logic [31:0] if_resp_inst;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
  logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
  logic [7:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_resp_rdata;
  logic [7:0]  mem_wmask;

  always #5 clock = ~clock;

  imem_dmem_arbiter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_req_addr    (if_req_addr),
    .if_resp_valid  (if_resp_valid),
    .if_resp_inst   (if_resp_inst),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wmask  (lsu_req_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_rdata (lsu_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model (transaction lifecycle) ----------------
  bit          chk_en = 1'b0;
  bit          m_busy, m_sent, m_back, m_own_lsu, m_last_lsu, m_wen, e_lsu_win;
  logic [63:0] m_addr, m_wdata, m_lsu_data;
  logic [7:0]  m_wmask;
  logic [31:0] m_inst;
  int          n_txn = 0;

  function automatic bit pick_lsu(input bit iv, input bit lv, input bit last_lsu);
    if (iv && lv) return RR_MODE ? !last_lsu : 1'b1;
    return lv;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_sent = 0; m_back = 0; m_own_lsu = 0; m_last_lsu = 1;
    m_wen = 0; m_addr = '0; m_wdata = '0; m_wmask = '0; m_inst = '0; m_lsu_data = '0;
  endtask

  task automatic model_deliver();
    m_back = 1;
    if (m_own_lsu) m_lsu_data = m_wen ? 64'd0 : mem_resp_rdata;
    else           m_inst = 32'(mem_resp_rdata >> (m_addr[2] ? 32 : 0));
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_step();
    if (!m_busy) begin
      if (if_req_valid || lsu_req_valid) begin
        m_busy = 1; m_sent = 0; m_back = 0;
        m_own_lsu = e_lsu_win;
        m_last_lsu = e_lsu_win;
        if (e_lsu_win) begin
          m_addr = lsu_req_addr & MASK; m_wen = lsu_req_wen;
          m_wdata = lsu_req_wdata; m_wmask = lsu_req_wmask;
        end else begin
          m_addr = if_req_addr & MASK; m_wen = 0; m_wdata = '0; m_wmask = '0;
        end
      end
    end else if (m_back) begin
      m_busy = 0;
      n_txn++;
      $display("txn %0d %s addr=%h wen=%0d data=%h", n_txn, m_own_lsu ? "LSU" : "IF ",
               m_addr, m_wen, m_own_lsu ? m_lsu_data : {32'd0, m_inst});
    end else if (!m_sent) begin
      if (mem_req_ready) begin
        m_sent = 1;
        if (mem_resp_valid) model_deliver();
      end
    end else if (mem_resp_valid) begin
      model_deliver();
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      if (!reset_n) model_clear();
      e_lsu_win = pick_lsu(if_req_valid, lsu_req_valid, m_last_lsu);
      check("if_req_ready",   if_req_ready,   reset_n && !m_busy && if_req_valid && !e_lsu_win);
      check("lsu_req_ready",  lsu_req_ready,  reset_n && !m_busy && lsu_req_valid && e_lsu_win);
      check("mem_req_valid",  mem_req_valid,  m_busy && !m_sent);
      check("if_resp_valid",  if_resp_valid,  m_busy && m_back && !m_own_lsu);
      check("lsu_resp_valid", lsu_resp_valid, m_busy && m_back && m_own_lsu);
      check("mem_addr",       mem_addr,       m_addr);
      check("mem_wen",        mem_wen,        m_wen);
      check("mem_wmask",      mem_wmask,      m_wmask);
      if (m_wen) check("mem_wdata", mem_wdata, m_wdata);
      check("if_resp_inst",   if_resp_inst,   m_inst);
      check("lsu_resp_rdata", lsu_resp_rdata, m_lsu_data);
      if (reset_n) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  int order_a[$];
  int gb[4];
  int ng;
  bit if_hs, lsu_hs;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    if_req_valid = 0; if_req_addr = '0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    model_clear();
    #1 reset_n = 0;
    chk_en = 1;
    #2;
    // reset state
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_if_ready", if_req_ready, 0);
    check("rst_lsu_ready", lsu_req_ready, 0);
    check("rst_if_resp", if_resp_valid, 0);
    check("rst_lsu_resp", lsu_resp_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_inst", if_resp_inst, 0);
    check("rst_rdata", lsu_resp_rdata, 0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1;

    // IF fetch, immediate memory, upper word selected
    tick();
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 64'h11223344_55667788;
    if_req_valid = 1; if_req_addr = 64'h8000_0004;
    #3 check("t1_if_ready", if_req_ready, 1); check("t1_lsu_ready", lsu_req_ready, 0);
    tick(); if_req_valid = 0;
    #3 check("t1_mem_valid", mem_req_valid, 1); check("t1_mem_addr", mem_addr, 64'h4);
    check("t1_mem_wen", mem_wen, 0); check("t1_if_ready_busy", if_req_ready, 0);
    tick();
    #3 check("t1_resp_valid", if_resp_valid, 1); check("t1_inst", if_resp_inst, 32'h11223344);
    tick();
    #3 check("t1_resp_pulse_end", if_resp_valid, 0); check("t1_inst_hold", if_resp_inst, 32'h11223344);

    // LSU store
    tick();
    mem_resp_rdata = 64'haaaa5555_aaaa5555;
    lsu_req_valid = 1; lsu_req_addr = 64'h8000_0010; lsu_req_wen = 1;
    lsu_req_wdata = 64'hdead; lsu_req_wmask = 8'h03;
    #3 check("t2_lsu_ready", lsu_req_ready, 1); check("t2_if_ready", if_req_ready, 0);
    tick(); lsu_req_valid = 0;
    #3 check("t2_mem_wen", mem_wen, 1); check("t2_mem_wmask", mem_wmask, 8'h03);
    check("t2_mem_addr", mem_addr, 64'h10); check("t2_mem_wdata", mem_wdata, 64'hdead);
    tick();
    #3 check("t2_resp_valid", lsu_resp_valid, 1); check("t2_rdata", lsu_resp_rdata, 0);
    check("t2_no_if_resp", if_resp_valid, 0);
    tick();
    #3 check("t2_resp_pulse_end", lsu_resp_valid, 0);

    // Simultaneous requests: each drops after its first grant
    tick();
    lsu_req_wen = 0;
    if_req_valid = 1; if_req_addr = 64'h8; lsu_req_valid = 1; lsu_req_addr = 64'h20;
    for (int c = 0; c < 30 && order_a.size() < 2; c++) begin
      #3;
      if_hs = if_req_valid && if_req_ready;
      lsu_hs = lsu_req_valid && lsu_req_ready;
      if (if_hs) order_a.push_back(0);
      if (lsu_hs) order_a.push_back(1);
      tick();
      if (if_hs) if_req_valid = 0;
      if (lsu_hs) lsu_req_valid = 0;
    end
    drain();
    check("t3_grants", order_a.size(), 2);
    if (order_a.size() == 2) begin
      check("t3_first", order_a[0], RR_MODE ? 0 : 1);
      check("t3_second", order_a[1], RR_MODE ? 1 : 0);
    end
    // Both held high continuously for four grants
    if_req_valid = 1; lsu_req_valid = 1;
    ng = 0;
    foreach (gb[i]) gb[i] = 9;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #3;
      if (if_req_valid && if_req_ready) begin gb[ng] = 0; ng++; end
      else if (lsu_req_valid && lsu_req_ready) begin gb[ng] = 1; ng++; end
      tick();
    end
    if_req_valid = 0; lsu_req_valid = 0;
    drain();
    check("t3b_grants", ng, 4);
    for (int i = 0; i < 4; i++) check("t3b_order", gb[i], RR_MODE ? (i % 2) : 1);

    // mem_req_ready low for 5 REQ cycles, then response delayed 4 cycles
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h01234567_89abcdef;
    if_req_valid = 1; if_req_addr = 64'hffff_ffff_8000_0100;
    #3 check("t4_if_ready", if_req_ready, 1);
    tick(); if_req_valid = 0; lsu_req_valid = 1; lsu_req_addr = 64'h40; lsu_req_wen = 0;
    for (int c = 0; c < 5; c++) begin
      #3 check("t4_mem_valid", mem_req_valid, 1); check("t4_mem_addr", mem_addr, 64'h100);
      check("t4_mem_wen", mem_wen, 0); check("t4_if_ready", if_req_ready, 0);
      check("t4_lsu_ready", lsu_req_ready, 0);
      tick();
    end
    mem_req_ready = 1; mem_resp_valid = 0;
    #3 check("t4_mem_valid_last", mem_req_valid, 1);
    tick();
    for (int c = 0; c < 4; c++) begin
      #3 check("t5_no_early_resp", if_resp_valid, 0); check("t5_mem_idle", mem_req_valid, 0);
      check("t5_lsu_ready", lsu_req_ready, 0);
      tick();
    end
    mem_resp_valid = 1;
    #3 check("t5_resp_after_strobe", if_resp_valid, 0);
    tick(); mem_resp_valid = 0;
    #3 check("t5_resp_valid", if_resp_valid, 1); check("t5_inst", if_resp_inst, 32'h89abcdef);
    tick();
    #3 check("t5_resp_end", if_resp_valid, 0); check("t5_lsu_ready_idle", lsu_req_ready, 1);
    tick(); lsu_req_valid = 0; mem_resp_valid = 1;
    drain();

    // Reset while waiting for memory data
    mem_req_ready = 1; mem_resp_valid = 0;
    if_req_valid = 1; if_req_addr = 64'h8000_0204;
    #3 check("t6_if_ready", if_req_ready, 1);
    tick(); if_req_valid = 0;
    tick();
    #1 reset_n = 0;
    #1;
    check("t6_mem_valid", mem_req_valid, 0); check("t6_mem_addr", mem_addr, 0);
    check("t6_mem_wdata", mem_wdata, 0); check("t6_inst", if_resp_inst, 0);
    check("t6_rdata", lsu_resp_rdata, 0); check("t6_if_ready", if_req_ready, 0);
    mem_resp_valid = 1;
    tick(); tick();
    #1 reset_n = 1;
    #2 check("t6_no_if_resp", if_resp_valid, 0); check("t6_no_lsu_resp", lsu_resp_valid, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      #3 check("t6_no_if_resp", if_resp_valid, 0); check("t6_idle", mem_req_valid, 0);
    end
    tick(); mem_resp_valid = 0;

    // Randomized traffic with one asynchronous reset in the middle
    if_hs = 0; lsu_hs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!if_req_valid || if_hs) begin
        if_req_valid = ($urandom_range(0, 1) == 1);
        if_req_addr = {$urandom, $urandom} & ~64'h3;
      end
      if (!lsu_req_valid || lsu_hs) begin
        lsu_req_valid = ($urandom_range(0, 1) == 1);
        lsu_req_addr = {$urandom, $urandom};
        lsu_req_wen = ($urandom_range(0, 1) == 1);
        lsu_req_wdata = {$urandom, $urandom};
        lsu_req_wmask = 8'($urandom);
      end
      mem_req_ready = ($urandom_range(0, 2) != 0);
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_resp_rdata = {$urandom, $urandom};
      if (cyc == 1500) reset_n = 0;
      if (cyc == 1503) reset_n = 1;
      #3;
      if_hs = if_req_valid && if_req_ready;
      lsu_hs = lsu_req_valid && lsu_req_ready;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
